// File: rtl/mem_pkg.sv
// Shared widths, default depth and FSM state encoding for the program memory.
package mem_pkg;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store one word per enabled edge.
  // NOTE: the array has no reset on purpose; clearing a RAM costs a port per word
  // and the loaded image must survive a controller reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_memory.sv
// Program memory with a boot loader: bytes streamed in while the CPU is held
// in reset, then the CPU is released and owns the write port.
module program_memory
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_COUNT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] memoryIn,
  output logic [DATA_W-1:0] memoryOut,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              cpu_clr,
  output logic              load_done,
  output logic              bus_err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(LOAD_COUNT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_ptr;
  logic              r_bus_err;
  logic              w_beat;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_beat  = (r_state == LOAD) && ld_valid;
  assign bus_err = r_bus_err;

  // State register; clr forces LOAD immediately so cpu_clr reasserts without a clock.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  // Next-state: LOAD until the final beat, one RELEASE cycle, then RUN until clr.
  // NOTE: defaulting every comb output first keeps the block free of latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (w_beat && (r_ptr == LAST_PTR)) w_next_state = RELEASE;
      RELEASE: w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = LOAD;
    endcase
  end

  // Outputs decoded from state alone.
  always_comb begin
    ld_ready  = 1'b0;
    cpu_clr   = 1'b1;
    load_done = 1'b0;
    case (r_state)
      LOAD:    ld_ready = 1'b1;
      RELEASE: ;
      RUN: begin
        cpu_clr   = 1'b0;
        load_done = 1'b1;
      end
      default: ld_ready = 1'b1;
    endcase
  end

  // Loader pointer: advances per accepted beat and stops on the last one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr <= '0;
    end else if (w_beat && (r_ptr != LAST_PTR)) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  // Sticky flag for a simultaneous CPU read and write while running.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_bus_err <= 1'b0;
    end else if ((r_state == RUN) && read && write) begin
      r_bus_err <= 1'b1;
    end
  end

  // Write-port mux: loader owns the port in LOAD, CPU in RUN, nobody in RELEASE.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = ld_data;
    case (r_state)
      LOAD: w_we = ld_valid;
      RUN: begin
        w_we    = write;
        w_waddr = AW'(address);
        w_wdata = memoryIn;
      end
      default: ;
    endcase
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (AW'(address)),
    .o_rdata (memoryOut)
  );

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: boot load, CPU access table, clr corners.
module tb_program_memory;

  logic       clk = 1'b0;
  logic       clr;
  logic       read;
  logic       write;
  logic [3:0] address;
  logic [7:0] memoryIn;
  logic [7:0] memoryOut;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cpu_clr;
  logic       load_done;
  logic       bus_err;

  program_memory dut (
    .clk       (clk),
    .clr       (clr),
    .read      (read),
    .write     (write),
    .address   (address),
    .memoryIn  (memoryIn),
    .memoryOut (memoryOut),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .cpu_clr   (cpu_clr),
    .load_done (load_done),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_err;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] img  [16];
  logic [7:0] model[16];
  logic [7:0] sb[$];
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic load_beat(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    img = '{8'h37, 8'h54, 8'h54, 8'h00, 8'h00, 8'h00, 8'h02, 8'h06,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    //           wr    rd    addr   din     dout    err
    vecs[0] = '{1'b1, 1'b0, 4'd3,  8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd9,  8'h3C, 8'h3C, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'd3,  8'hFF, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd2,  8'h11, 8'h11, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'd15, 8'h77, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 8'hC3, 8'hC3, 1'b1};

    clr = 1'b1; read = 1'b0; write = 1'b0; address = '0;
    memoryIn = '0; ld_valid = 1'b0; ld_data = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_cpu_clr",   cpu_clr,   1);
    check("rst_ld_ready",  ld_ready,  1);
    check("rst_load_done", load_done, 0);
    check("rst_bus_err",   bus_err,   0);
    clr = 1'b0;

    // Boot image with gaps; a CPU write during LOAD must be ignored
    for (int i = 0; i < 16; i++) begin
      sb.push_back(img[i]);
      model[i] = img[i];
      load_beat(img[i]);
      if (i < 15) begin
        if (i == 0 || i == 8) begin
          check("load_ld_ready", ld_ready, 1);
          check("load_cpu_clr",  cpu_clr,  1);
        end
        if (i == 5) begin
          write = 1'b1; address = 4'd5; memoryIn = 8'hFF;
          @(posedge clk); #1;
          write = 1'b0;
        end else if (i % 3 == 1) begin
          @(posedge clk); #1;
        end
      end
    end

    // First edge after last beat: RELEASE; CPU write and loader beat both ignored
    check("rel_ld_ready",  ld_ready,  0);
    check("rel_cpu_clr",   cpu_clr,   1);
    check("rel_load_done", load_done, 0);
    write = 1'b1; address = 4'd0; memoryIn = 8'hEE;
    ld_valid = 1'b1; ld_data = 8'h99;
    @(posedge clk); #1;
    check("run_cpu_clr",   cpu_clr,   0);
    check("run_load_done", load_done, 1);
    check("run_ld_ready",  ld_ready,  0);
    write = 1'b0;
    // Loader beat in RUN must not touch the array
    @(posedge clk); #1;
    ld_valid = 1'b0;
    check("run_hold_done", load_done, 1);

    // Read back the loaded image through the scoreboard
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      check($sformatf("image[%0d]", a), memoryOut, sb.pop_front());
    end
    @(posedge clk); #1;

    // CPU access table in RUN
    for (int v = 0; v < 6; v++) begin
      write    = vecs[v].wr;
      read     = vecs[v].rd;
      address  = vecs[v].addr;
      memoryIn = vecs[v].din;
      sb.push_back(vecs[v].exp_dout);
      #1;
      check($sformatf("vec%0d_pre", v), memoryOut, model[vecs[v].addr]);
      @(posedge clk); #1;
      write = 1'b0;
      read  = 1'b0;
      check($sformatf("vec%0d_dout", v), memoryOut, sb.pop_front());
      check($sformatf("vec%0d_err", v),  bus_err,   vecs[v].exp_err);
      if (vecs[v].wr) model[vecs[v].addr] = vecs[v].din;
    end

    // Asynchronous clr in RUN: immediate effect, array preserved
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    check("aclr_cpu_clr",   cpu_clr,   1);
    check("aclr_load_done", load_done, 0);
    check("aclr_ld_ready",  ld_ready,  1);
    check("aclr_bus_err",   bus_err,   0);
    address = 4'd3;
    #1;
    check("aclr_keep_mem3", memoryOut, 8'hA5);
    @(posedge clk); #1;
    clr = 1'b0;

    // Partial load, clr, restart at address 0
    for (int k = 0; k < 5; k++) begin
      load_beat(8'h10 + 8'(k));
      check($sformatf("part_ready%0d", k), ld_ready, 1);
    end
    #2;
    clr = 1'b1;
    #1;
    check("mid_clr_ready", ld_ready, 1);
    @(posedge clk); #1;
    clr = 1'b0;
    check("post_clr_ready", ld_ready, 1);
    load_beat(8'hAA);
    check("restart_ready",   ld_ready, 1);
    check("restart_cpu_clr", cpu_clr,  1);
    address = 4'd0;
    #1;
    check("restart_mem0", memoryOut, 8'hAA);
    address = 4'd1;
    #1;
    check("restart_mem1", memoryOut, 8'h11);
    address = 4'd4;
    #1;
    check("restart_mem4", memoryOut, 8'h14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
